interval_span_fill: RTL and testbench

//  Downstream consumer of the per-line interval stage. Takes one scanline span (y, s, t, colour).

---
 rtl/interval_span_fill.sv | 119 +++++++++++
 tb/tb_interval_span_fill.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/interval_span_fill.sv
// Scanline span filler: clips one (y, s..t) span to the screen and emits one
// framebuffer pixel write per accepted cycle, then a one-cycle done pulse.
module interval_span_fill #(
  parameter int CORDW = 10,
  parameter int COLRW = 12,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDRW = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CORDW-1:0] y,
  input  logic [CORDW-1:0] s,
  input  logic [CORDW-1:0] t,
  input  logic [COLRW-1:0] colr,
  input  logic             fb_ready,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [COLRW-1:0] fb_colr,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for a span, in_ready high
  // SETUP | clip span, compute line base address
  // FILL  | one pixel write per cycle while fb_ready
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [CORDW-1:0] XMAX = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] YMAX = CORDW'(V_RES - 1);

  state_t           state;
  logic [CORDW-1:0] y_r, s_r, t_r, x_cur, te;
  logic [COLRW-1:0] colr_r;
  logic [ADDRW-1:0] base;

  logic             empty;
  logic [CORDW-1:0] te_w;
  logic [ADDRW-1:0] base_w;

  always_comb begin
    empty  = (s_r > t_r) || (s_r > XMAX) || (y_r > YMAX);
    te_w   = (t_r > XMAX) ? XMAX : t_r;
    base_w = ADDRW'(y_r) * ADDRW'(H_RES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_colr  <= '0;
      done     <= 1'b0;
      y_r      <= '0;
      s_r      <= '0;
      t_r      <= '0;
      colr_r   <= '0;
      x_cur    <= '0;
      te       <= '0;
      base     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            y_r      <= y;
            s_r      <= s;
            t_r      <= t;
            colr_r   <= colr;
            in_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          x_cur <= s_r;
          te    <= te_w;
          base  <= base_w;
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // first write is presented straight out of SETUP
            fb_we   <= 1'b1;
            fb_addr <= base_w + ADDRW'(s_r);
            fb_colr <= colr_r;
            state   <= FILL;
          end
        end
        FILL: begin
          if (fb_ready) begin
            if (x_cur == te) begin
              fb_we <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              x_cur   <= x_cur + CORDW'(1);
              fb_addr <= base + ADDRW'(x_cur + CORDW'(1));
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          fb_we    <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_span_fill.sv
// Bench for interval_span_fill: directed and random spans checked against a
// list-of-addresses reference built from the clipping rules.
module tb_interval_span_fill;
  localparam int CORDW = 10;
  localparam int COLRW = 12;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int ADDRW = 19;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CORDW-1:0] y, s, t;
  logic [COLRW-1:0] colr;
  logic             fb_ready;
  logic             fb_we;
  logic [ADDRW-1:0] fb_addr;
  logic [COLRW-1:0] fb_colr;
  logic             done;

  int total = 0;
  int bad   = 0;

  interval_span_fill #(
    .CORDW(CORDW), .COLRW(COLRW), .H_RES(H_RES), .V_RES(V_RES), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .s(s), .t(t), .colr(colr), .fb_ready(fb_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: fb_ready always high; 1: random back-pressure; 2: 3-cycle stall on 2nd write
  task automatic run_span(input int y_i, input int s_i, input int t_i, input int c_i, input int mode);
    int  exp_q[$];
    int  te, k, nw, last_k, stall_left;
    bit  seen_done, prev_stall, stalled_once, rdy;
    logic [ADDRW-1:0] prev_addr;
    if (s_i <= t_i && s_i < H_RES && y_i < V_RES) begin
      te = (t_i > H_RES - 1) ? H_RES - 1 : t_i;
      for (int x = s_i; x <= te; x++) exp_q.push_back(y_i * H_RES + x);
    end
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    y = CORDW'(y_i);
    s = CORDW'(s_i);
    t = CORDW'(t_i);
    colr = COLRW'(c_i);
    fb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("setup_fb_we", fb_we, 0);
    chk("setup_in_ready", in_ready, 0);
    k = 1; nw = 0; last_k = 0; stall_left = 0;
    seen_done = 0; prev_stall = 0; stalled_once = 0; prev_addr = '0;
    while (!seen_done && k < 3000) begin
      if (prev_stall) begin
        chk("stall_hold_we", fb_we, 1);
        chk("stall_hold_addr", fb_addr, prev_addr);
      end
      if (done) begin
        seen_done = 1;
        chk("write_count", nw, exp_q.size());
        chk("done_cycle", k, (exp_q.size() == 0) ? 2 : last_k + 1);
        chk("done_fb_we", fb_we, 0);
      end else if (fb_we) begin
        if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
        else if (mode == 2) begin
          if (nw == 1 && !stalled_once) begin
            stall_left = 3;
            stalled_once = 1;
          end
          rdy = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else rdy = 1;
        fb_ready = rdy;
        if (nw == 0 && !prev_stall) chk("first_write_latency", k, 2);
        if (rdy) begin
          if (nw < exp_q.size()) chk("fb_addr", fb_addr, exp_q[nw]);
          else chk("extra_write", nw, exp_q.size() - 1);
          chk("fb_colr", fb_colr, c_i);
          last_k = k;
          nw++;
        end
        prev_stall = !rdy;
        prev_addr = fb_addr;
      end else begin
        prev_stall = 0;
        fb_ready = 1'b1;
      end
      if (!seen_done) begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    fb_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int ry, rs, rt;
    rst_n = 1'b0; in_valid = 1'b0; y = '0; s = '0; t = '0; colr = '0; fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_colr", fb_colr, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    run_span(2, 5, 7, 12'hF00, 0);
    run_span(0, 1, 0, 12'h0AA, 0);
    run_span(0, 630, 700, 12'h123, 0);
    run_span(479, 0, 0, 12'h456, 0);
    run_span(480, 0, 5, 12'h789, 0);
    run_span(1, 0, 3, 12'hABC, 2);
    run_span(10, 100, 100, 12'h001, 1);
    run_span(5, 640, 700, 12'h002, 0);
    run_span(3, 600, 1023, 12'h003, 1);

    for (int i = 0; i < 25; i++) begin
      ry = $urandom_range(0, 500);
      rs = $urandom_range(0, 700);
      rt = rs + $urandom_range(0, 40) - 5;
      if (rt < 0) rt = 0;
      if (rt > 1023) rt = 1023;
      run_span(ry, rs, rt, $urandom_range(0, 4095), $urandom_range(0, 1));
    end

    // abort a long span with reset while writes are in flight
    @(negedge clk);
    in_valid = 1'b1; y = CORDW'(7); s = '0; t = CORDW'(639); colr = 12'h5A5; fb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_fb_we", fb_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_fb_we", fb_we, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_fb_we", fb_we, 0);
    end
    chk("post_abort_in_ready", in_ready, 1);
    run_span(0, 0, 2, 12'h0F0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
